// File: rtl/i2s_sample_fifo.sv
// Stereo sample FIFO behind the I2S receiver: captures one L/R pair per frame on the ws falling edge.
// Optional I2S_SAMPLE_FIFO_DROP_FIRST_EN discards the first (possibly partial) frame after reset.
module i2s_sample_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     mclk,
  input  logic                     rst,
  input  logic                     ws,
  input  logic [WIDTH-1:0]         rx_data_l,
  input  logic [WIDTH-1:0]         rx_data_r,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data_l,
  output logic [WIDTH-1:0]         out_data_r,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clear_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = 2 * WIDTH;

  logic          ws_d1_q, ws_d1_d;
  logic          ws_d2_q, ws_d2_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic [EW-1:0] mem [DEPTH];

  logic          frame_done_c;
  logic          push_req_c;
  logic          push_ok_c;
  logic          push_drop_c;
  logic          pop_c;
  logic          empty_c;
  logic          full_c;
  logic [EW-1:0] head_c;

`ifdef I2S_SAMPLE_FIFO_DROP_FIRST_EN
  logic          primed_q, primed_d;
`endif

  // Frame detection, flow control and pointer/flag next-state.
  always_comb begin
    ws_d1_d      = ws;
    ws_d2_d      = ws_d1_q;
    frame_done_c = ws_d2_q & ~ws_d1_q;

    empty_c   = (wr_ptr_q == rd_ptr_q);
    full_c    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    out_valid = ~empty_c;
    pop_c     = out_valid & out_ready;

`ifdef I2S_SAMPLE_FIFO_DROP_FIRST_EN
    primed_d   = primed_q | frame_done_c;
    push_req_c = frame_done_c & primed_q;
`else
    push_req_c = frame_done_c;
`endif
    push_ok_c   = push_req_c & (~full_c | pop_c);
    push_drop_c = push_req_c & ~push_ok_c;

    wr_ptr_d = push_ok_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_c     ? rd_ptr_q + PW'(1) : rd_ptr_q;

    // A drop in the same cycle as a clear keeps the flag set.
    if (push_drop_c) begin
      overflow_d = 1'b1;
    end else if (clear_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    head_c     = mem[rd_ptr_q[AW-1:0]];
    out_data_l = out_valid ? head_c[EW-1:WIDTH] : '0;
    out_data_r = out_valid ? head_c[WIDTH-1:0]  : '0;
    count      = wr_ptr_q - rd_ptr_q;
    overflow   = overflow_q;
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      ws_d1_q    <= 1'b0;
      ws_d2_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      ws_d1_q    <= ws_d1_d;
      ws_d2_q    <= ws_d2_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef I2S_SAMPLE_FIFO_DROP_FIRST_EN
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      primed_q <= 1'b0;
    end else begin
      primed_q <= primed_d;
    end
  end
`endif

  // Sample storage is intentionally left unreset.
  always_ff @(posedge mclk) begin
    if (push_ok_c) begin
      mem[wr_ptr_q[AW-1:0]] <= {rx_data_l, rx_data_r};
    end
  end

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Randomized self-checking bench for i2s_sample_fifo against a queue-based reference model.
module tb_i2s_sample_fifo;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;

  logic              mclk = 1'b0;
  logic              rst = 1'b1;
  logic              ws = 1'b0;
  logic [WIDTH-1:0]  rx_data_l = '0;
  logic [WIDTH-1:0]  rx_data_r = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out_data_l;
  logic [WIDTH-1:0]  out_data_r;
  logic [$clog2(DEPTH):0] count;
  logic              overflow;
  logic              clear_ovf = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  bit rnd_en = 1'b0;

  i2s_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .mclk      (mclk),
    .rst       (rst),
    .ws        (ws),
    .rx_data_l (rx_data_l),
    .rx_data_r (rx_data_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data_l(out_data_l),
    .out_data_r(out_data_r),
    .count     (count),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: ws samples per edge, frame pushed two edges after a high-to-low transition.
  logic [31:0] mq[$];
  bit m_ovf = 1'b0;
  bit s1 = 1'b0, s2 = 1'b0;
  bit m_primed = 1'b0;

  always @(posedge mclk or negedge rst) begin : model
    bit fd, want, pop, drop;
    if (!rst) begin
      mq.delete();
      m_ovf    = 1'b0;
      s1       = 1'b0;
      s2       = 1'b0;
      m_primed = 1'b0;
    end else begin
      fd   = s2 && !s1;
      want = fd;
`ifdef I2S_SAMPLE_FIFO_DROP_FIRST_EN
      if (fd && !m_primed) begin
        want     = 1'b0;
        m_primed = 1'b1;
      end
`endif
      pop  = (mq.size() > 0) && out_ready;
      drop = 1'b0;
      if (pop) void'(mq.pop_front());
      if (want) begin
        if (mq.size() < DEPTH) mq.push_back({rx_data_l, rx_data_r});
        else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (clear_ovf) m_ovf = 1'b0;
      s2 = s1;
      s1 = ws;
    end
  end

  // Every cycle, compare all outputs with the model away from the active edge.
  always @(negedge mclk) begin
    logic [31:0] hd;
    hd = (mq.size() > 0) ? mq[0] : 32'h0;
    check("valid", 32'(out_valid), 32'(mq.size() > 0));
    check("count", 32'(count), 32'(mq.size()));
    check("ovf", 32'(overflow), 32'(m_ovf));
    check("data", {out_data_l, out_data_r}, hd);
  end

  task automatic tick();
    @(negedge mclk);
    if (rnd_en) begin
      out_ready = 1'($urandom_range(0, 1));
      clear_ovf = ($urandom_range(0, 15) == 0);
    end
  endtask

  // One I2S frame: ws high for hi cycles, then low for lo (>=2) cycles with new data.
  task automatic frame(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                       input int hi, input int lo, input bit clr_at_push, input bit rdy_at_push);
    tick();
    ws = 1'b1;
    repeat (hi - 1) tick();
    tick();
    ws = 1'b0;
    rx_data_l = l;
    rx_data_r = r;
    tick();
    if (clr_at_push) clear_ovf = 1'b1;
    if (rdy_at_push) out_ready = 1'b1;
    tick();
    if (clr_at_push) clear_ovf = 1'b0;
    if (rdy_at_push) out_ready = 1'b0;
    repeat (lo - 2) tick();
  endtask

  initial begin
    logic [WIDTH-1:0] first_l, first_r, last_l, last_r;
    #1 rst = 1'b0;

    // Reset held while ws toggles.
    repeat (10) begin
      tick();
      ws = ~ws;
    end
    tick();
    ws = 1'b0;
    rst = 1'b1;
    check("rst_count", 32'(count), 32'd0);

    // Two frames without consumer, then drain.
    frame(16'hFFFF, 16'h0000, 3, 4, 1'b0, 1'b0);
`ifdef I2S_SAMPLE_FIFO_DROP_FIRST_EN
    check("two_f1_count", 32'(count), 32'd0);
`else
    check("two_f1_count", 32'(count), 32'd1);
`endif
    frame(16'h8111, 16'h0000, 3, 4, 1'b0, 1'b0);
`ifdef I2S_SAMPLE_FIFO_DROP_FIRST_EN
    check("two_f2_count", 32'(count), 32'd1);
    check("two_head_l", 32'(out_data_l), 32'h8111);
`else
    check("two_f2_count", 32'(count), 32'd2);
    check("two_head_l", 32'(out_data_l), 32'hFFFF);
`endif
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("two_drain", 32'(count), 32'd0);

    // Latency: ws falls before edge k, valid only after edge k+1.
    tick();
    ws = 1'b1;
    repeat (3) tick();
    ws = 1'b0;
    rx_data_l = 16'h1234;
    rx_data_r = 16'h5678;
    @(posedge mclk); #1;
    check("lat_k", 32'(out_valid), 32'd0);
    @(posedge mclk); #1;
    check("lat_k1", 32'(out_valid), 32'd1);
    check("lat_data", {out_data_l, out_data_r}, 32'h12345678);
    tick();
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;

    // Overflow: DEPTH+1 frames with no consumer.
    first_l = 16'($urandom);
    first_r = 16'($urandom);
    frame(first_l, first_r, 2, 3, 1'b0, 1'b0);
    repeat (DEPTH) frame(16'($urandom), 16'($urandom), 2, 3, 1'b0, 1'b0);
    check("ovf_count", 32'(count), 32'(DEPTH));
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head", {out_data_l, out_data_r}, {first_l, first_r});
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    tick();
    check("ovf_clear", 32'(overflow), 32'd0);
    frame(16'hAAAA, 16'h5555, 2, 3, 1'b1, 1'b0);
    check("ovf_set_wins", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;

    // Full FIFO: push and pop on the same edge.
    last_l = 16'hC0DE;
    last_r = 16'hBEEF;
    frame(last_l, last_r, 2, 3, 1'b0, 1'b1);
    check("full_pp_count", 32'(count), 32'(DEPTH));
    check("full_pp_ovf", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    repeat (DEPTH - 1) tick();
    check("full_pp_tail", {out_data_l, out_data_r}, {last_l, last_r});
    tick();
    out_ready = 1'b0;
    check("full_pp_empty", 32'(count), 32'd0);

    // Randomized traffic.
    rnd_en = 1'b1;
    repeat (250) frame(16'($urandom), 16'($urandom), int'($urandom_range(1, 5)),
                       int'($urandom_range(2, 6)), 1'b0, 1'b0);
    rnd_en = 1'b0;
    out_ready = 1'b1;
    clear_ovf = 1'b1;
    repeat (DEPTH + 1) tick();
    out_ready = 1'b0;
    clear_ovf = 1'b0;

    // Mid-run reset with three entries queued.
    repeat (3) frame(16'($urandom), 16'($urandom), 2, 3, 1'b0, 1'b0);
    check("mid_count3", 32'(count), 32'd3);
    tick();
    ws = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_data", {out_data_l, out_data_r}, 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    ws = 1'b0;
    repeat (5) tick();
    check("mid_no_push", 32'(count), 32'd0);
    frame(16'h0F0F, 16'hF0F0, 2, 3, 1'b0, 1'b0);
`ifdef I2S_SAMPLE_FIFO_DROP_FIRST_EN
    check("mid_first_frame", 32'(count), 32'd0);
`else
    check("mid_first_frame", 32'(count), 32'd1);
`endif
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
